// File: rtl/pixel_framebuffer_if.sv
// Pixel-write stream plus collision read-back port between the drawing/game
// logic (master) and the shadow framebuffer (slave).
interface pixel_framebuffer_if #(
    parameter int unsigned CW = 3
);
    logic          clear;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [CW-1:0] colour;
    logic          writeEn;
    logic          rd_req;
    logic [9:0]    rd_x;
    logic [9:0]    rd_y;
    logic          rd_valid;
    logic [CW-1:0] rd_colour;
    logic          busy;

    modport master (
        output clear, x, y, colour, writeEn, rd_req, rd_x, rd_y,
        input  rd_valid, rd_colour, busy
    );

    modport slave (
        input  clear, x, y, colour, writeEn, rd_req, rd_x, rd_y,
        output rd_valid, rd_colour, busy
    );
endinterface

// File: rtl/pixel_framebuffer.sv
// On-chip 160x120 shadow framebuffer: accepts the pixel-write stream, serves
// 1-cycle-latency colour reads and zeroes itself after reset or on request.
module pixel_framebuffer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned CW     = 3,
    parameter int unsigned AW     = 15
) (
    input logic               clk,
    input logic               reset,
    pixel_framebuffer_if.slave fb
);
    localparam int unsigned   DEPTH  = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [9:0]    WIDTH_C  = 10'(WIDTH);
    localparam logic [9:0]    HEIGHT_C = 10'(HEIGHT);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    state_e        state_q;
    logic [AW-1:0] clr_q;
    logic          busy_q;
    logic          rd_valid_q;
    logic [CW-1:0] rd_colour_q;

    logic [CW-1:0] mem [DEPTH];

    logic          idle;
    logic          wr_ok;
    logic          rd_ok;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [CW-1:0] mem_wdata;

    // y*160 as two shifts; the result fits AW bits for every in-range pixel.
    function automatic logic [AW-1:0] map_addr(input logic [9:0] px, input logic [9:0] py);
        logic [AW-1:0] yy;
        yy = AW'(py);
        return (yy << 7) + (yy << 5) + AW'(px);
    endfunction

    always_comb begin
        idle    = (state_q == S_IDLE);
        wr_ok   = (fb.x < WIDTH_C) && (fb.y < HEIGHT_C);
        rd_ok   = (fb.rd_x < WIDTH_C) && (fb.rd_y < HEIGHT_C);
        wr_addr = map_addr(fb.x, fb.y);
        rd_addr = map_addr(fb.rd_x, fb.rd_y);

        // The clear sequencer owns the single write port while running.
        mem_we    = !idle || (fb.writeEn && wr_ok);
        mem_waddr = idle ? wr_addr : clr_q;
        mem_wdata = idle ? fb.colour : '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_q       <= '0;
            busy_q      <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_colour_q <= '0;
        end else begin
            rd_valid_q <= fb.rd_req && idle;
            if (fb.rd_req && idle) begin
                rd_colour_q <= rd_ok ? mem[rd_addr] : '0;
            end

            case (state_q)
                S_CLEAR: begin
                    if (fb.clear) begin
                        clr_q <= '0;
                    end else if (clr_q == LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_q <= clr_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (fb.clear) begin
                        state_q <= S_CLEAR;
                        clr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    clr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign fb.rd_valid  = rd_valid_q;
    assign fb.rd_colour = rd_colour_q;
    assign fb.busy      = busy_q;
endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- Sink end of the pixel-write stream (x, y, colour, writeEn) produced by the drawing blocks (platform, ball, bricks).
- Stores every accepted pixel write in an on-chip 160x120 shadow framebuffer.
- Provides a registered read-back port so game logic can query the colour at any coordinate (collision detection).
- Contains a clear sequencer that zeroes the whole buffer after reset or on request.

Parameters:
- WIDTH, 160, horizontal resolution in pixels.
- HEIGHT, 120, vertical resolution in pixels.
- CW, 3, colour width in bits.
- AW, 15, memory address width; must satisfy 2^AW >= WIDTH*HEIGHT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  single-cycle request to zero the entire buffer.
- x  input  10  write x coordinate.
- y  input  10  write y coordinate.
- colour  input  CW  write colour.
- writeEn  input  1  write strobe, one pixel per cycle.
- rd_req  input  1  read request strobe.
- rd_x  input  10  read x coordinate.
- rd_y  input  10  read y coordinate.
- rd_valid  output  1  one-cycle pulse marking rd_colour valid.
- rd_colour  output  CW  read data.
- busy  output  1  high while the clear sequencer runs.

Behaviour:
- Reset (asynchronous):
  - FSM goes to S_CLEAR, clear address counter goes to 0.
  - busy=1, rd_valid=0, rd_colour=0.
  - Memory contents are not reset directly; the sequencer zeroes them.
- FSM states: S_CLEAR and S_IDLE.
- S_CLEAR:
  - Each cycle writes 0 to mem[clr_addr], then increments clr_addr.
  - At clr_addr == WIDTH*HEIGHT-1 (19199), after that write, goes to S_IDLE.
  - Clear from reset completes in exactly 19200 cycles; busy falls on the cycle S_IDLE is entered.
- S_IDLE:
  - clear=1 enters S_CLEAR with clr_addr=0 on the next edge; busy=1 from that edge.
  - clear=1 while already in S_CLEAR restarts the counter at 0.
- Address mapping: addr = y*WIDTH + x, computed at AW bits. Multiply-by-160 is implemented as (y<<7)+(y<<5).
- Writes:
  - In S_IDLE, writeEn=1 with x<WIDTH and y<HEIGHT writes colour to mem[addr] on that edge.
  - Out-of-range coordinates are silently ignored.
  - writeEn during S_CLEAR is dropped; the clear always wins.
  - writeEn and clear in the same S_IDLE cycle: the pixel write is performed, then clearing begins next cycle.
- Reads:
  - rd_req=1 in S_IDLE registers the request; rd_valid=1 and rd_colour=mem[rd_addr] on the next cycle.
  - Fixed latency of 1 and full throughput: back-to-back requests give back-to-back valids.
  - Out-of-range read: rd_valid=1, rd_colour=0.
  - rd_req during S_CLEAR is dropped (no rd_valid).
  - Read and write to the same address in the same cycle return the old data (read-before-write).
- rd_colour holds its last value when rd_valid=0.
- Reset asserted mid-clear or mid-read:
  - Sequencer restarts from address 0.
  - A pending rd_valid is cancelled.
- Memory is a single inferred simple-dual-port RAM, 19200 x CW. No other storage of pixel data is permitted.

Test Plan:
- Reset pulse, then count cycles -> busy=1 for exactly 19200 cycles; read of (159,119) afterwards -> rd_valid next cycle, rd_colour=0.
- After clear, write (32,110,3'b100), then read (32,110) the following cycle -> rd_colour=3'b100 with 1-cycle latency; read (33,110) -> 0.
- Write (160,5,3'b111) and (5,120,3'b111) -> ignored; reads of (0,6) and (5,0) stay 0, and an out-of-range read returns rd_valid=1, rd_colour=0.
- Same-cycle write (10,10,3'b010) and read (10,10), with a prior value of 3'b001 -> rd_colour=3'b001; a repeat read -> 3'b010.
- Issue clear mid-game, assert writeEn and rd_req during busy -> no rd_valid, no write persists; after 19200 cycles all probed pixels read 0.
- Assert reset at clr_addr=5000 -> busy stays high and the full clear takes 19200 more cycles; pending rd_valid suppressed.
